// File: rtl/rom_port_pkg.sv
// rtl/rom_port_pkg.sv - shared types, constants and address check for the ROM read port
package rom_port_pkg;

   localparam int ROM_RSP_DEPTH  = 2;
   localparam int ROM_DATA_WIDTH = 32;

   typedef struct packed {
      logic [ROM_DATA_WIDTH-1:0] data;
      logic                      err;
   } rom_rsp_t;

   // Misaligned when any byte-offset bit is set; out of range when any bit above the word address is set.
   function automatic logic rom_addr_err(input logic [63:0] addr,
                                         input int unsigned word_bits,
                                         input int unsigned ofs);
      logic [63:0] low_mask;
      low_mask = (64'd1 << ofs) - 64'd1;
      return ((addr & low_mask) != 64'd0) || ((addr >> (word_bits + ofs)) != 64'd0);
   endfunction

endpackage

// File: rtl/rom_rsp_fifo.sv
// rtl/rom_rsp_fifo.sv - two-entry response FIFO holding {data, err}
module rom_rsp_fifo
   import rom_port_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   localparam int CNT_W     = $clog2(ROM_RSP_DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_push_err,
   input  logic                  i_pop,
   output logic [CNT_W-1:0]      o_count,
   output logic [DATA_WIDTH-1:0] o_head_data,
   output logic                  o_head_err
);

   logic [DATA_WIDTH-1:0] mem_data [ROM_RSP_DEPTH];
   logic                  mem_err  [ROM_RSP_DEPTH];
   logic                  wr_ptr;
   logic                  rd_ptr;

   always_ff @(posedge i_clk) begin
      if (i_push) begin
         mem_data[wr_ptr] <= i_push_data;
         mem_err[wr_ptr]  <= i_push_err;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         o_count <= '0;
      end else begin
         if (i_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (i_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({i_push, i_pop})
            2'b10:   o_count <= o_count + CNT_W'(1);
            2'b01:   o_count <= o_count - CNT_W'(1);
            default: o_count <= o_count;
         endcase
      end
   end

   assign o_head_data = mem_data[rd_ptr];
   assign o_head_err  = mem_err[rd_ptr];

endmodule

// File: rtl/rom_read_port.sv
// rtl/rom_read_port.sv - valid/ready read front end for a one-cycle-latency synchronous ROM
module rom_read_port
   import rom_port_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDRESS_WIDTH   = 10,
   parameter int BYTE_ADDR_WIDTH = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic [BYTE_ADDR_WIDTH-1:0] i_req_addr,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [DATA_WIDTH-1:0]      o_rsp_data,
   output logic                       o_rsp_error,
   output logic [ADDRESS_WIDTH-1:0]   o_rom_address,
   input  logic [DATA_WIDTH-1:0]      i_rom_read_data
);

   localparam int OFS   = $clog2(DATA_WIDTH / 8);
   localparam int CNT_W = $clog2(ROM_RSP_DEPTH + 1);

   logic                  accept;
   logic                  req_err;
   logic                  s1_valid;
   logic                  s1_err;
   logic [DATA_WIDTH-1:0] s1_data;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W:0]        occupancy;
   logic [DATA_WIDTH-1:0] fifo_head_data;
   logic                  fifo_head_err;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  bypass_take;

   assign o_rom_address = i_req_addr[ADDRESS_WIDTH+OFS-1:OFS];
   assign req_err       = rom_addr_err(64'(i_req_addr), ADDRESS_WIDTH, OFS);

   // Ready looks only at registered occupancy, so it never depends on this cycle's handshakes.
   assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
   assign o_req_ready = !i_rst && (occupancy < (CNT_W+1)'(ROM_RSP_DEPTH));
   assign accept      = i_req_valid && o_req_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_err <= req_err;
         end
      end
   end

   // ROM output is only meaningful the cycle after an accept, and error requests return zero.
   assign s1_data = (s1_valid && !s1_err) ? i_rom_read_data : '0;

   assign fifo_empty  = (fifo_count == '0);
   assign bypass_take = fifo_empty && s1_valid && i_rsp_ready;
   assign fifo_push   = s1_valid && !bypass_take;
   assign fifo_pop    = !fifo_empty && i_rsp_ready;

   rom_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (fifo_push),
      .i_push_data (s1_data),
      .i_push_err  (s1_err),
      .i_pop       (fifo_pop),
      .o_count     (fifo_count),
      .o_head_data (fifo_head_data),
      .o_head_err  (fifo_head_err)
   );

   assign o_rsp_valid = !fifo_empty || s1_valid;
   assign o_rsp_data  = fifo_empty ? s1_data : fifo_head_data;
   assign o_rsp_error = fifo_empty ? (s1_valid && s1_err) : fifo_head_err;

endmodule
